// File: rtl/shift_request_sequencer.sv
// Shift request sequencer: accepts one shift request, drives the shifter,
// and hands the captured result (or a timeout error) to the display stage.
module shift_request_sequencer #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 4,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_times,
    output logic [WIDTH-1:0] sh_value,
    output logic             sh_dir,
    output logic [CNT_W-1:0] sh_times,
    output logic             sh_start,
    input  logic             sh_ready,
    input  logic [WIDTH-1:0] sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_error,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] GUARD_C = TW'(GUARD);
    localparam logic [TW-1:0] LAST_C  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] SAT_C   = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    cnt_q;
    logic [TW-1:0]    cnt_d;
    logic [WIDTH-1:0] sh_value_q;
    logic             sh_dir_q;
    logic [CNT_W-1:0] sh_times_q;
    logic             sh_start_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_error_q;
    logic             ready_seen;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != SAT_C) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // The shifter's ready flag may still be high from the previous job,
    // so it is only trusted once the guard window has elapsed.
    assign ready_seen = sh_ready && (cnt_q >= GUARD_C);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sh_value_q   <= '0;
            sh_dir_q     <= 1'b0;
            sh_times_q   <= '0;
            sh_start_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_error_q  <= 1'b0;
        end else begin
            sh_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sh_value_q <= in_value;
                        sh_dir_q   <= in_dir;
                        sh_times_q <= in_times;
                        sh_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (ready_seen) begin
                        out_result_q <= sh_result;
                        out_error_q  <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (cnt_q == LAST_C) begin
                        out_result_q <= '0;
                        out_error_q  <= 1'b1;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign sh_value   = sh_value_q;
    assign sh_dir     = sh_dir_q;
    assign sh_times   = sh_times_q;
    assign sh_start   = sh_start_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_error  = out_error_q;

endmodule

// File: tb/tb_shift_request_sequencer.sv
// Bench for shift_request_sequencer with a behavioural shifter and a
// result scoreboard.
module tb_shift_request_sequencer;

    localparam int WIDTH   = 16;
    localparam int CNT_W   = 4;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_value = '0;
    logic             in_dir = 1'b0;
    logic [CNT_W-1:0] in_times = '0;
    logic [WIDTH-1:0] sh_value;
    logic             sh_dir;
    logic [CNT_W-1:0] sh_times;
    logic             sh_start;
    logic             sh_ready;
    logic [WIDTH-1:0] sh_result;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             out_error;
    logic             busy;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             err;
    } exp_t;
    exp_t sb_q[$];

    // shifter model
    logic             silent = 1'b0;
    logic             man = 1'b0;
    logic             t_ready = 1'b0;
    logic [WIDTH-1:0] t_result = '0;
    logic             m_ready;
    logic [WIDTH-1:0] m_result;
    logic [WIDTH-1:0] m_res;
    int               m_rem;

    shift_request_sequencer #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .GUARD(GUARD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_dir(in_dir), .in_times(in_times),
        .sh_value(sh_value), .sh_dir(sh_dir), .sh_times(sh_times),
        .sh_start(sh_start), .sh_ready(sh_ready), .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_error(out_error), .busy(busy)
    );

    always #5 clk = ~clk;

    assign sh_ready  = man ? t_ready : m_ready;
    assign sh_result = man ? t_result : m_result;

    always @(posedge clk) begin
        if (!reset) begin
            m_rem    <= 0;
            m_ready  <= 1'b0;
            m_result <= '0;
            m_res    <= '0;
        end else if (sh_start) begin
            m_rem   <= int'(sh_times) + 2;
            m_ready <= 1'b0;
            m_res   <= sh_dir ? (sh_value >> sh_times) : (sh_value << sh_times);
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_ready  <= !silent;
                m_result <= m_res;
            end
        end
    end

    always @(negedge clk) begin
        if (sh_start === 1'b1) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic accept(input logic [WIDTH-1:0] v, input logic d,
                          input logic [CNT_W-1:0] t,
                          input logic [WIDTH-1:0] er, input logic ee);
        int n = 0;
        exp_t e;
        in_value = v;
        in_dir   = d;
        in_times = t;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL accept_ready: in_ready=%b after %0d cycles, need 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = er;
        e.err = ee;
        sb_q.push_back(e);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (out_valid !== 1'b1 && cyc < budget);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sh_start, out_valid, out_error, busy} !== 4'b0) begin
                failures++;
                $display("FAIL reset_flags: start/valid/err/busy=%b need 0000",
                         {sh_start, out_valid, out_error, busy});
            end
            checks++;
            if ({out_result, sh_value, sh_dir, sh_times} !== '0) begin
                failures++;
                $display("FAIL reset_data: res=%h val=%h dir=%b times=%h need 0",
                         out_result, sh_value, sh_dir, sh_times);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: in_ready=%b need 1", in_ready);
        end
    endtask

    task automatic test_right_shift;
        int s0, cyc;
        exp_t e;
        s0 = start_cnt;
        accept(16'h00F0, 1'b1, 4'd4, 16'h000F, 1'b0);
        wait_valid(60, cyc);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL rs_latency: out_valid after %0d cycles need 8", cyc);
        end
        checks++;
        if (start_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL rs_start_pulses: got %0d need 1", start_cnt - s0);
        end
        checks++;
        if (sh_value !== 16'h00F0 || sh_dir !== 1'b1 || sh_times !== 4'd4) begin
            failures++;
            $display("FAIL rs_operands: val=%h dir=%b times=%h need 00f0 1 4",
                     sh_value, sh_dir, sh_times);
        end
        e = sb_q.pop_front();
        checks++;
        if (out_result !== e.res || out_error !== e.err) begin
            failures++;
            $display("FAIL rs_result: res=%h err=%b need %h %b",
                     out_result, out_error, e.res, e.err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rs_release: valid=%b in_ready=%b need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_hold;
        int cyc;
        exp_t e;
        accept(16'h8001, 1'b0, 4'd0, 16'h8001, 1'b0);
        wait_valid(60, cyc);
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL hold_latency: out_valid after %0d cycles need 4", cyc);
        end
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== e.res || out_error !== e.err
                || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable: valid=%b res=%h err=%b in_ready=%b need 1 %h %b 0",
                         out_valid, out_result, out_error, in_ready, e.res, e.err);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: valid=%b busy=%b need 0 0", out_valid, busy);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        exp_t e;
        silent = 1'b1;
        accept(16'h1111, 1'b0, 4'd3, 16'h0000, 1'b1);
        wait_valid(80, cyc);
        checks++;
        if (cyc !== TIMEOUT + 1) begin
            failures++;
            $display("FAIL to_latency: out_valid after %0d cycles need %0d", cyc, TIMEOUT + 1);
        end
        e = sb_q.pop_front();
        checks++;
        if (out_result !== e.res || out_error !== e.err) begin
            failures++;
            $display("FAIL to_result: res=%h err=%b need %h %b",
                     out_result, out_error, e.res, e.err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        silent = 1'b0;
    endtask

    task automatic test_guard;
        int cyc;
        bit early = 1'b0;
        exp_t e;
        man = 1'b1;
        t_ready = 1'b1;
        t_result = 16'hDEAD;
        accept(16'h0003, 1'b0, 4'd2, 16'hBEEF, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) early = 1'b1;
            if (k == 3) t_ready = 1'b0;
            if (k == 5) begin
                t_ready  = 1'b1;
                t_result = 16'hBEEF;
            end
        end
        checks++;
        if (early !== 1'b0) begin
            failures++;
            $display("FAIL guard_stale: out_valid=%b before real ready, need 0", early);
        end
        wait_valid(20, cyc);
        checks++;
        if (cyc + 5 !== 6) begin
            failures++;
            $display("FAIL guard_latency: out_valid after %0d cycles need 6", cyc + 5);
        end
        e = sb_q.pop_front();
        checks++;
        if (out_result !== e.res || out_error !== e.err) begin
            failures++;
            $display("FAIL guard_result: res=%h err=%b need %h %b",
                     out_result, out_error, e.res, e.err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        t_result = 16'h5A5A;
        accept(16'h0004, 1'b1, 4'd1, 16'h5A5A, 1'b0);
        wait_valid(20, cyc);
        checks++;
        if (cyc !== GUARD + 2) begin
            failures++;
            $display("FAIL guard_edge: out_valid after %0d cycles need %0d", cyc, GUARD + 2);
        end
        e = sb_q.pop_front();
        checks++;
        if (out_result !== e.res || out_error !== e.err) begin
            failures++;
            $display("FAIL guard_edge_result: res=%h err=%b need %h %b",
                     out_result, out_error, e.res, e.err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        t_ready = 1'b0;
        man = 1'b0;
    endtask

    task automatic test_reset_mid;
        int cyc, s0;
        bit seen = 1'b0;
        exp_t e;
        silent = 1'b1;
        accept(16'hFFFF, 1'b1, 4'd5, 16'h0000, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb_q.delete();
        silent = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle: busy=%b in_ready=%b valid=%b need 0 1 0",
                     busy, in_ready, out_valid);
        end
        s0 = start_cnt;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || start_cnt !== s0) begin
            failures++;
            $display("FAIL mid_reset_quiet: valid_seen=%b starts=%0d need 0 0",
                     seen, start_cnt - s0);
        end
        accept(16'h1234, 1'b1, 4'd1, 16'h091A, 1'b0);
        wait_valid(60, cyc);
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL mid_latency: out_valid after %0d cycles need 5", cyc);
        end
        e = sb_q.pop_front();
        checks++;
        if (out_result !== e.res || out_error !== e.err) begin
            failures++;
            $display("FAIL mid_result: res=%h err=%b need %h %b",
                     out_result, out_error, e.res, e.err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] vals[3] = '{16'hA5C3, 16'hFFFF, 16'h0001};
        logic             dirs[3] = '{1'b0, 1'b1, 1'b0};
        logic [CNT_W-1:0] tms[3]  = '{4'd15, 4'd15, 4'd7};
        logic [WIDTH-1:0] x;
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = dirs[i] ? (vals[i] >> tms[i]) : (vals[i] << tms[i]);
            accept(vals[i], dirs[i], tms[i], x, 1'b0);
            wait_valid(60, cyc);
            checks++;
            if (cyc !== int'(tms[i]) + 4) begin
                failures++;
                $display("FAIL b2b_latency[%0d]: %0d cycles need %0d", i, cyc, int'(tms[i]) + 4);
            end
            e = sb_q.pop_front();
            checks++;
            if (out_result !== e.res || out_error !== e.err) begin
                failures++;
                $display("FAIL b2b_result[%0d]: res=%h err=%b need %h %b",
                         i, out_result, out_error, e.res, e.err);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (sb_q.size() !== 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drain: queue=%0d in_ready=%b need 0 1", sb_q.size(), in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_right_shift();
        test_hold();
        test_timeout();
        test_guard();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
